// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the async FIFO write-side controller.
package fifo_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Binary to reflected-gray conversion; callers cast the result to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Full when the write gray pointer equals the read gray pointer with its two MSBs inverted.
  // ptr_w is the pointer width (address bits plus the wrap bit).
  function automatic logic is_full(input logic [31:0] wgray,
                                   input logic [31:0] rgray,
                                   input int unsigned ptr_w);
    logic [31:0] mask;
    logic [31:0] top2;
    mask = (32'd1 << ptr_w) - 32'd1;
    top2 = 32'd3 << (ptr_w - 2);
    return ((wgray ^ rgray ^ top2) & mask) == '0;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing the read-side gray pointer into the w_clk domain.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Metastability stage followed by the output stage.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Write-side controller for the async FIFO: round-robin arbiter with burst lock,
// RAM write port, binary/gray write pointer and full flag.
module fifo_write_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATAIN_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned FIFO_DEPTH_BIT = 4,
  parameter int unsigned MAX_BURST      = 4
) (
  input  logic                              w_clk,
  input  logic                              w_rst_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                req_last,
  input  logic [NUM_REQ*DATAIN_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                ack,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              w_en,
  output logic [FIFO_DEPTH_BIT-1:0]         write_addr,
  output logic [DATAIN_WIDTH-1:0]           data_write,
  output logic                              flag_full,
  output logic [FIFO_DEPTH_BIT:0]           wptr_gray,
  input  logic [FIFO_DEPTH_BIT:0]           rptr_gray
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GPTR_W = FIFO_DEPTH_BIT + 1;

  state_t                    state, state_n;
  logic [IDX_W-1:0]          owner, owner_n;
  logic [IDX_W-1:0]          last_owner, last_owner_n;
  logic [NUM_REQ-1:0]        grant_n;
  logic [BEAT_W-1:0]         beat_cnt, beat_cnt_n;
  logic [PTR_W-1:0]          wptr_bin, wptr_bin_n;
  logic [GPTR_W-1:0]         rptr_sync;
  logic                      pick_valid;
  logic [IDX_W-1:0]          pick_idx;
  int unsigned               cand;
  logic [DATAIN_WIDTH-1:0]   req_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[i*DATAIN_WIDTH +: DATAIN_WIDTH];
  end

  sync_2ff #(
    .WIDTH (GPTR_W)
  ) u_rptr_sync (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .d       (rptr_gray),
    .q       (rptr_sync)
  );

  assign write_addr = wptr_bin[FIFO_DEPTH_BIT-1:0];
  assign flag_full  = is_full(32'(wptr_gray), 32'(rptr_sync), GPTR_W);

  // Round-robin pick: first active request after the previous owner, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_owner) + k) % NUM_REQ;
      if (!pick_valid && req[IDX_W'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state, RAM write port and requester acknowledge.
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    grant_n      = grant;
    beat_cnt_n   = beat_cnt;
    wptr_bin_n   = wptr_bin;
    w_en         = 1'b0;
    ack          = '0;
    data_write   = '0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n           = BURST;
          owner_n           = pick_idx;
          grant_n           = '0;
          grant_n[pick_idx] = 1'b1;
          beat_cnt_n        = '0;
        end
      end
      BURST: begin
        if (req[owner]) begin
          // A full FIFO stalls the burst in place without consuming a beat.
          if (!flag_full) begin
            w_en       = 1'b1;
            ack[owner] = 1'b1;
            data_write = req_word[owner];
            wptr_bin_n = wptr_bin + 1'b1;
            beat_cnt_n = beat_cnt + 1'b1;
            if (req_last[owner] || (beat_cnt == BEAT_W'(MAX_BURST - 1))) begin
              state_n      = IDLE;
              grant_n      = '0;
              last_owner_n = owner;
            end
          end
        end else begin
          state_n      = IDLE;
          grant_n      = '0;
          last_owner_n = owner;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, ownership and pointer registers; gray pointer is taken from the next binary value.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      grant      <= '0;
      beat_cnt   <= '0;
      wptr_bin   <= '0;
      wptr_gray  <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      grant      <= grant_n;
      beat_cnt   <= beat_cnt_n;
      wptr_bin   <= wptr_bin_n;
      wptr_gray  <= GPTR_W'(bin2gray(32'(wptr_bin_n)));
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed table, corner sequences, random vs model.
module tb_fifo_write_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int DB    = 4;
  localparam int MB    = 4;
  localparam int PW    = DB + 1;

  logic              w_clk = 1'b0;
  logic              w_rst_n;
  logic [NR-1:0]     req, req_last, ack, grant;
  logic [NR*DW-1:0]  req_data;
  logic              w_en, flag_full;
  logic [DB-1:0]     write_addr;
  logic [DW-1:0]     data_write;
  logic [PW-1:0]     wptr_gray, rptr_gray;

  fifo_write_arbiter #(
    .NUM_REQ        (NR),
    .DATAIN_WIDTH   (DW),
    .FIFO_DEPTH     (DEPTH),
    .FIFO_DEPTH_BIT (DB),
    .MAX_BURST      (MB)
  ) dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .req        (req),
    .req_last   (req_last),
    .req_data   (req_data),
    .ack        (ack),
    .grant      (grant),
    .w_en       (w_en),
    .write_addr (write_addr),
    .data_write (data_write),
    .flag_full  (flag_full),
    .wptr_gray  (wptr_gray),
    .rptr_gray  (rptr_gray)
  );

  always #5 w_clk = ~w_clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: owner bookkeeping plus plain write/read counts.
  bit m_busy;
  int m_owner, m_last, m_beats, m_wcnt, m_rs1, m_rs2;
  int rcount;

  typedef struct packed {
    logic          wen;
    logic [NR-1:0] ack;
    logic [NR-1:0] grant;
    logic [DB-1:0] addr;
    logic          full;
    logic [DW-1:0] data;
  } obs_t;

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] last;
    logic          exp_wen;
    logic [NR-1:0] exp_grant;
    logic [DB-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int gray2bin(input int g);
    int b;
    b = g;
    for (int s = 1; s < PW; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic bit model_full();
    return ((m_wcnt - gray2bin(m_rs2)) & (2*DEPTH - 1)) == DEPTH;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = NR - 1; m_beats = 0; m_wcnt = 0; m_rs1 = 0; m_rs2 = 0;
  endtask

  task automatic model_check();
    bit            full, wen;
    logic [NR-1:0] eg;
    logic [DW-1:0] ed;
    full = model_full();
    eg   = m_busy ? NR'(1 << m_owner) : '0;
    wen  = m_busy && req[m_owner] && !full;
    ed   = wen ? req_data[m_owner*DW +: DW] : '0;
    chk("grant",      32'(grant),      32'(eg));
    chk("w_en",       32'(w_en),       32'(wen));
    chk("ack",        32'(ack),        wen ? 32'(eg) : 32'd0);
    chk("data_write", 32'(data_write), 32'(ed));
    chk("write_addr", 32'(write_addr), 32'(m_wcnt % DEPTH));
    chk("flag_full",  32'(flag_full),  32'(full));
    chk("wptr_gray",  32'(wptr_gray),  32'(gray_of(m_wcnt)));
  endtask

  task automatic model_update();
    bit full;
    full = model_full();
    if (!m_busy) begin
      for (int k = 1; k <= NR; k++) begin
        if (!m_busy && req[(m_last + k) % NR]) begin
          m_busy = 1; m_owner = (m_last + k) % NR; m_beats = 0;
        end
      end
    end else if (req[m_owner]) begin
      if (!full) begin
        m_wcnt = (m_wcnt + 1) % (2*DEPTH);
        m_beats++;
        if (req_last[m_owner] || m_beats == MB) begin
          m_busy = 0; m_last = m_owner;
        end
      end
    end else begin
      m_busy = 0; m_last = m_owner;
    end
    m_rs2 = m_rs1;
    m_rs1 = int'(rptr_gray);
  endtask

  task automatic step_obs(output obs_t o);
    @(negedge w_clk);
    model_check();
    o.wen = w_en; o.ack = ack; o.grant = grant; o.addr = write_addr;
    o.full = flag_full; o.data = data_write;
    @(posedge w_clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    req = '0; req_last = '0; rptr_gray = '0; rcount = 0;
    w_rst_n = 1'b0;
    @(posedge w_clk);
    @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"},   32'(ack),        0);
    chk({tag, "_grant"}, 32'(grant),      0);
    chk({tag, "_wen"},   32'(w_en),       0);
    chk({tag, "_addr"},  32'(write_addr), 0);
    chk({tag, "_data"},  32'(data_write), 0);
    chk({tag, "_full"},  32'(flag_full),  0);
    chk({tag, "_wgray"}, 32'(wptr_gray),  0);
  endtask

  initial begin
    vec_t vecs[10];
    obs_t o;
    int   n, nw, found, prev_addr;
    bit   wrap_seen;

    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(16'hA000 + i);
    req = '0; req_last = '0; rptr_gray = '0;
    w_rst_n = 1'b0;
    #2;
    check_all_zero("por");

    // Round-robin with single-word bursts: one write every other cycle, owners 0,1,2,3,0.
    vecs[0] = '{4'hF, 4'hF, 1'b0, 4'b0000, 4'd0, 16'h0000};
    vecs[1] = '{4'hF, 4'hF, 1'b1, 4'b0001, 4'd0, 16'hA000};
    vecs[2] = '{4'hF, 4'hF, 1'b0, 4'b0000, 4'd1, 16'h0000};
    vecs[3] = '{4'hF, 4'hF, 1'b1, 4'b0010, 4'd1, 16'hA001};
    vecs[4] = '{4'hF, 4'hF, 1'b0, 4'b0000, 4'd2, 16'h0000};
    vecs[5] = '{4'hF, 4'hF, 1'b1, 4'b0100, 4'd2, 16'hA002};
    vecs[6] = '{4'hF, 4'hF, 1'b0, 4'b0000, 4'd3, 16'h0000};
    vecs[7] = '{4'hF, 4'hF, 1'b1, 4'b1000, 4'd3, 16'hA003};
    vecs[8] = '{4'hF, 4'hF, 1'b0, 4'b0000, 4'd4, 16'h0000};
    vecs[9] = '{4'hF, 4'hF, 1'b1, 4'b0001, 4'd4, 16'hA000};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      req = vecs[i].req; req_last = vecs[i].last;
      step_obs(o);
      chk("rr_grant", 32'(o.grant), 32'(vecs[i].exp_grant));
      chk("rr_wen",   32'(o.wen),   32'(vecs[i].exp_wen));
      chk("rr_ack",   32'(o.ack),   vecs[i].exp_wen ? 32'(vecs[i].exp_grant) : 32'd0);
      chk("rr_addr",  32'(o.addr),  32'(vecs[i].exp_addr));
      chk("rr_data",  32'(o.data),  32'(vecs[i].exp_data));
    end

    // Burst cap: requester 1 never signals last -> exactly MB words, IDLE bubble, regrant.
    do_reset();
    req = 4'b0010;
    step_obs(o);
    n = 0;
    for (int i = 0; i < MB; i++) begin
      step_obs(o);
      if (o.ack == 4'b0010) n++;
      chk("cap_addr", 32'(o.addr), 32'(i));
    end
    chk("cap_acks", 32'(n), 32'(MB));
    step_obs(o);
    chk("cap_idle_grant", 32'(o.grant), 0);
    chk("cap_idle_wen",   32'(o.wen),   0);
    step_obs(o);
    chk("cap_regrant", 32'(o.grant), 32'(4'b0010));
    chk("cap_next_addr", 32'(o.addr), 32'(MB));

    // Full: fill all slots with the reader parked, stall, then release one slot.
    do_reset();
    req = 4'b0001; req_last = 4'b0001;
    nw = 0;
    for (int g = 0; g < 60 && nw < DEPTH; g++) begin
      step_obs(o);
      if (o.wen) nw++;
    end
    chk("full_fill_writes", 32'(nw), 32'(DEPTH));
    step_obs(o);
    chk("full_flag", 32'(o.full), 1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step_obs(o);
      if (o.wen) n++;
    end
    chk("full_stall_no_wen", 32'(n), 0);
    chk("full_stall_grant",  32'(o.grant), 32'(4'b0001));
    rptr_gray = PW'(gray_of(1));
    found = 0; n = 0;
    for (int i = 1; i <= 8 && found == 0; i++) begin
      step_obs(o);
      if (o.wen) begin found = 1; n = i; end
    end
    chk("full_resume", 32'(found), 1);
    chk("full_resume_lat_2to3", 32'(n >= 2 && n <= 3), 1);
    chk("full_resume_addr", 32'(o.addr), 0);

    // Wrap: 40 writes with reads keeping pace.
    do_reset();
    req = 4'b1000;
    nw = 0; wrap_seen = 0; prev_addr = -1;
    for (int g = 0; g < 200 && nw < 40; g++) begin
      rcount = m_wcnt;
      rptr_gray = PW'(gray_of(rcount));
      step_obs(o);
      if (o.wen) begin
        if (prev_addr == DEPTH - 1 && o.addr == 0) wrap_seen = 1;
        prev_addr = int'(o.addr);
        nw++;
      end
    end
    req = '0;
    chk("wrap_writes", 32'(nw), 40);
    chk("wrap_addr_15_to_0", 32'(wrap_seen), 1);
    chk("wrap_wptr_gray", 32'(wptr_gray), 32'(gray_of(40 % (2*DEPTH))));

    // Drop: requester 2 withdraws after two words; next grant goes to 3.
    do_reset();
    req = 4'b0100;
    step_obs(o);
    step_obs(o);
    chk("drop_w0", 32'(o.ack), 32'(4'b0100));
    step_obs(o);
    chk("drop_w1_addr", 32'(o.addr), 1);
    req = 4'b0000;
    step_obs(o);
    chk("drop_no_wen", 32'(o.wen), 0);
    chk("drop_grant_held", 32'(o.grant), 32'(4'b0100));
    req = 4'b1111; req_last = 4'b1111;
    step_obs(o);
    chk("drop_idle", 32'(o.grant), 0);
    step_obs(o);
    chk("drop_next_owner", 32'(o.grant), 32'(4'b1000));

    // Asynchronous reset in the middle of a burst.
    do_reset();
    req = 4'b1111; req_last = 4'b0000;
    step_obs(o);
    step_obs(o);
    #2;
    w_rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");

    // Random traffic with a slow reader so the FIFO regularly fills.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req      = NR'($urandom);
      req_last = NR'($urandom) & NR'($urandom);
      req_data = {$urandom, $urandom};
      if (rcount != m_wcnt && $urandom_range(0, 3) == 0) rcount = (rcount + 1) % (2*DEPTH);
      rptr_gray = PW'(gray_of(rcount));
      step_obs(o);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
